// File: rtl/read_arbiter_pkg.sv
// Shared types and default widths for the two-requester burst read arbiter.
package read_arbiter_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int LEN_W_DEF  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        BURST = 2'd2
    } state_t;

endpackage

// File: rtl/rr_pick.sv
// Two-way winner select: round-robin on the last-served pointer, or fixed
// priority to requester 0 when READ_ARB_FIXED_PRIO_EN is defined. Purely combinational.
module rr_pick (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] win
);

`ifdef READ_ARB_FIXED_PRIO_EN
    logic unused_ptr;
    assign unused_ptr = ptr;

    always_comb begin
        win = 2'b00;
        if (req[0])
            win = 2'b01;
        else if (req[1])
            win = 2'b10;
    end
`else
    // On a tie the requester that was not served last wins.
    always_comb begin
        win = 2'b00;
        case (req)
            2'b01:   win = 2'b01;
            2'b10:   win = 2'b10;
            2'b11:   win = ptr ? 2'b01 : 2'b10;
            default: win = 2'b00;
        endcase
    end
`endif

endmodule

// File: rtl/read_arbiter.sv
// Arbitrates two burst read requesters and walks the winner's addresses (GRANT then len+1 BURST beats).
// Optional READ_ARB_FIXED_PRIO_EN makes requester 0 win every tie instead of round-robin.
module read_arbiter
    import read_arbiter_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        req,
    input  logic [ADDR_W-1:0] base0,
    input  logic [ADDR_W-1:0] base1,
    input  logic [LEN_W-1:0]  len0,
    input  logic [LEN_W-1:0]  len1,
    output logic [1:0]        gnt,
    output logic [ADDR_W-1:0] value,
    output logic              rd_valid,
    output logic [1:0]        done,
    output logic              busy
);

    state_t              state_q, state_d;
    logic [LEN_W-1:0]    beat_q;
    logic [LEN_W-1:0]    len_q;
    logic [ADDR_W-1:0]   base_q;
    logic [ADDR_W-1:0]   value_q;
    logic                win_q;
    logic                ptr_q;
    logic [1:0]          pick_win;
    logic                pick_any;
    logic                last_beat;
    logic                win_req;
    logic [ADDR_W-1:0]   addr;

    rr_pick u_rr_pick (
        .req (req),
        .ptr (ptr_q),
        .win (pick_win)
    );

    assign pick_any  = |pick_win;
    assign win_req   = req[win_q];
    assign last_beat = (beat_q == len_q);
    assign addr      = base_q + ADDR_W'(beat_q);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pick_any) state_d = GRANT;
            GRANT:   state_d = BURST;
            // A dropped request still lets the current beat out, then aborts.
            BURST:   if (!win_req || last_beat) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state_q != IDLE);
        rd_valid = (state_q == BURST);
        gnt      = 2'b00;
        if (busy)
            gnt = win_q ? 2'b10 : 2'b01;
        value    = rd_valid ? addr : value_q;
        done     = (rd_valid && win_req && last_beat) ? gnt : 2'b00;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            beat_q  <= '0;
            len_q   <= '0;
            base_q  <= '0;
            value_q <= '0;
            win_q   <= 1'b0;
            ptr_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    // Pointer moves at grant so the loser wins the next tie.
                    if (pick_any) begin
                        win_q  <= pick_win[1];
                        ptr_q  <= pick_win[1];
                        base_q <= pick_win[1] ? base1 : base0;
                        len_q  <= pick_win[1] ? len1 : len0;
                        beat_q <= '0;
                    end
                end
                GRANT: beat_q <= '0;
                BURST: begin
                    beat_q  <= beat_q + LEN_W'(1);
                    value_q <= addr;
                end
                default: beat_q <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_read_arbiter.sv
// Randomized self-checking bench: a transaction-level model predicts winner and beat trace per burst.
module tb_read_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] req;
    logic [7:0] base0, base1;
    logic [3:0] len0, len1;
    logic [1:0] gnt;
    logic [7:0] value;
    logic       rd_valid;
    logic [1:0] done;
    logic       busy;

    int         errors = 0;
    int         checks = 0;
    int         lp = 1;
    logic [7:0] last_val = 8'h00;

    always #5 clk = ~clk;

    read_arbiter #(.ADDR_W(8), .LEN_W(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .req      (req),
        .base0    (base0),
        .base1    (base1),
        .len0     (len0),
        .len1     (len1),
        .gnt      (gnt),
        .value    (value),
        .rd_valid (rd_valid),
        .done     (done),
        .busy     (busy)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [1:0] eg, input logic [7:0] ev,
                             input logic erv, input logic [1:0] ed, input logic eb);
        chk({tag, ".gnt"},      32'(gnt),      32'(eg));
        chk({tag, ".value"},    32'(value),    32'(ev));
        chk({tag, ".rd_valid"}, 32'(rd_valid), 32'(erv));
        chk({tag, ".done"},     32'(done),     32'(ed));
        chk({tag, ".busy"},     32'(busy),     32'(eb));
    endtask

    function automatic int predict(input logic [1:0] r);
        if (r == 2'b01) return 0;
        if (r == 2'b10) return 1;
`ifdef READ_ARB_FIXED_PRIO_EN
        return 0;
`else
        return (lp == 0) ? 1 : 0;
`endif
    endfunction

    task automatic scramble();
        base0 = 8'($urandom);
        base1 = 8'($urandom);
        len0  = 4'($urandom);
        len1  = 4'($urandom);
    endtask

    // Called at posedge+1 of an IDLE cycle; returns at posedge+1 of the following IDLE cycle.
    task automatic run_burst(input string tag, input logic [1:0] r,
                             input logic [7:0] b0, input logic [7:0] b1,
                             input logic [3:0] l0, input logic [3:0] l1, input int abort_at);
        int         w;
        int         n;
        logic [1:0] g;
        logic [7:0] b;
        logic [7:0] v;
        req = r; base0 = b0; base1 = b1; len0 = l0; len1 = l1;
        @(negedge clk);
        check_out({tag, ".idle"}, 2'b00, last_val, 1'b0, 2'b00, 1'b0);
        @(posedge clk); #1;
        if (r == 2'b00) return;
        w  = predict(r);
        lp = w;
        g  = (w == 1) ? 2'b10 : 2'b01;
        b  = (w == 1) ? b1 : b0;
        n  = int'((w == 1) ? l1 : l0) + 1;
        scramble();
        @(negedge clk);
        check_out({tag, ".grant"}, g, last_val, 1'b0, 2'b00, 1'b1);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            scramble();
            if (k == abort_at) req[w] = 1'b0;
            v = b + 8'(k);
            @(negedge clk);
            check_out($sformatf("%s.beat%0d", tag, k), g, v, 1'b1,
                      (k == n - 1 && k != abort_at) ? g : 2'b00, 1'b1);
            last_val = v;
            if (k == abort_at) break;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b0;
        req   = 2'b11;
        base0 = 8'h20; base1 = 8'h80; len0 = 4'd0; len1 = 4'd0;
        #12;
        check_out("reset", 2'b00, 8'h00, 1'b0, 2'b00, 1'b0);
        @(posedge clk); #1;
        reset = 1'b1;

        // Both requesting from reset: requester 0 first, then alternation.
        run_burst("tie0", 2'b11, 8'h20, 8'h80, 4'd0, 4'd0, -1);
        run_burst("tie1", 2'b11, 8'h20, 8'h80, 4'd0, 4'd0, -1);
        run_burst("tie2", 2'b11, 8'h20, 8'h80, 4'd0, 4'd0, -1);
        run_burst("nores", 2'b00, 8'h00, 8'h00, 4'd0, 4'd0, -1);
        run_burst("basic", 2'b01, 8'h10, 8'h55, 4'd3, 4'd7, -1);
        run_burst("wrap", 2'b10, 8'h33, 8'hFE, 4'd9, 4'd3, -1);
        run_burst("abort", 2'b01, 8'h40, 8'h00, 4'd3, 4'd1, 1);
        run_burst("maxlen", 2'b01, 8'hF8, 8'h00, 4'd15, 4'd0, -1);

        // Reset on the third beat of a requester-0 burst.
        req = 2'b01; base0 = 8'h60; len0 = 4'd5;
        @(posedge clk); #1;
        lp = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_mid.value_pre", 32'(value), 32'h62);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        check_out("rst_mid", 2'b00, 8'h00, 1'b0, 2'b00, 1'b0);
        lp = 1;
        last_val = 8'h00;
        @(posedge clk); #1;
        reset = 1'b1;
        run_burst("post_rst", 2'b11, 8'h05, 8'h90, 4'd1, 4'd2, -1);

        for (int i = 0; i < 40; i++) begin
            int ab;
            ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 6)) : -1;
            run_burst($sformatf("rnd%0d", i), 2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
                      4'($urandom_range(0, 6)), 4'($urandom_range(0, 6)), ab);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
